// File: rtl/iic_reg_seq.sv
// rtl/iic_reg_seq.sv - register read/write sequencer driving the iic_mst command port
module iic_reg_seq #(
    parameter int DEV_NACK_RETRY = 2
) (
    input  logic       i_SysClock,
    input  logic       i_ResetN,
    input  logic       i_ReqValid,
    output logic       o_ReqReady,
    input  logic       i_ReqRead,
    input  logic [6:0] i_DevAddr,
    input  logic [7:0] i_RegAddr,
    input  logic [7:0] i_WrData,
    input  logic [3:0] i_RdLen,
    output logic       o_RdValid,
    output logic [7:0] o_RdData,
    output logic       o_RespValid,
    output logic [1:0] o_RespErr,
    output logic       o_MstCmdValid,
    output logic [3:0] o_MstCmd,
    output logic [7:0] o_MstTxByte,
    output logic       o_MstSetAck,
    input  logic       i_MstDone,
    input  logic       i_MstGetAck,
    input  logic [7:0] i_MstRxByte
);
    localparam logic [3:0] CMD_START    = 4'd1;
    localparam logic [3:0] CMD_WRDATA   = 4'd2;
    localparam logic [3:0] CMD_RDDATA   = 4'd3;
    localparam logic [3:0] CMD_STOP     = 4'd4;
    localparam logic [3:0] CMD_PRESTART = 4'd5;
    localparam logic [3:0] RETRY_MAX    = 4'(DEV_NACK_RETRY);

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_DEVW, S_REG, S_WDATA, S_PRESTART,
        S_RSTART, S_DEVR, S_RDATA, S_STOP, S_RESP
    } state_t;

    state_t     state;
    logic       waiting;
    logic       rd_req;
    logic [6:0] dev_addr;
    logic [7:0] reg_addr;
    logic [7:0] wr_data;
    logic [3:0] rd_len;
    logic [3:0] byte_cnt;
    logic [3:0] retry_cnt;
    logic       retrying;
    logic [1:0] err_code;
    logic [3:0] issue_cmd;
    logic [7:0] issue_tx;

    assign o_ReqReady = (state == S_IDLE);

    always_comb begin
        issue_cmd = 4'd0;
        issue_tx  = 8'h00;
        case (state)
            S_START, S_RSTART: issue_cmd = CMD_START;
            S_DEVW:     begin issue_cmd = CMD_WRDATA; issue_tx = {dev_addr, 1'b0}; end
            S_REG:      begin issue_cmd = CMD_WRDATA; issue_tx = reg_addr; end
            S_WDATA:    begin issue_cmd = CMD_WRDATA; issue_tx = wr_data; end
            S_DEVR:     begin issue_cmd = CMD_WRDATA; issue_tx = {dev_addr, 1'b1}; end
            S_PRESTART: issue_cmd = CMD_PRESTART;
            S_RDATA:    issue_cmd = CMD_RDDATA;
            S_STOP:     issue_cmd = CMD_STOP;
            default:    ;
        endcase
    end

    always_ff @(posedge i_SysClock or negedge i_ResetN) begin
        if (!i_ResetN) begin
            state         <= S_IDLE;
            waiting       <= 1'b0;
            rd_req        <= 1'b0;
            dev_addr      <= 7'd0;
            reg_addr      <= 8'd0;
            wr_data       <= 8'd0;
            rd_len        <= 4'd0;
            byte_cnt      <= 4'd0;
            retry_cnt     <= 4'd0;
            retrying      <= 1'b0;
            err_code      <= 2'd0;
            o_RdValid     <= 1'b0;
            o_RdData      <= 8'd0;
            o_RespValid   <= 1'b0;
            o_RespErr     <= 2'd0;
            o_MstCmdValid <= 1'b0;
            o_MstCmd      <= 4'd0;
            o_MstTxByte   <= 8'd0;
            o_MstSetAck   <= 1'b0;
        end else begin
            o_MstCmdValid <= 1'b0;
            o_RdValid     <= 1'b0;
            o_RespValid   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_ReqValid) begin
                        rd_req    <= i_ReqRead;
                        dev_addr  <= i_DevAddr;
                        reg_addr  <= i_RegAddr;
                        wr_data   <= i_WrData;
                        rd_len    <= i_RdLen;
                        byte_cnt  <= 4'd0;
                        retry_cnt <= 4'd0;
                        retrying  <= 1'b0;
                        err_code  <= 2'd0;
                        state     <= S_START;
                        // Issue START straight from the accept cycle when the master is free
                        if (i_MstDone) begin
                            o_MstCmdValid <= 1'b1;
                            o_MstCmd      <= CMD_START;
                            o_MstTxByte   <= 8'h00;
                            o_MstSetAck   <= 1'b0;
                            waiting       <= 1'b1;
                        end else begin
                            waiting <= 1'b0;
                        end
                    end
                end
                S_RESP: state <= S_IDLE;
                default: begin
                    if (!waiting) begin
                        if (i_MstDone) begin
                            o_MstCmdValid <= 1'b1;
                            o_MstCmd      <= issue_cmd;
                            o_MstTxByte   <= issue_tx;
                            o_MstSetAck   <= (state == S_RDATA) && (byte_cnt == rd_len);
                            waiting       <= 1'b1;
                        end
                    end else if (i_MstDone && !o_MstCmdValid) begin
                        // Done is still high while the master samples our strobe, hence the guard
                        waiting <= 1'b0;
                        case (state)
                            S_START:    state <= S_DEVW;
                            S_PRESTART: state <= S_RSTART;
                            S_RSTART:   state <= S_DEVR;
                            S_DEVW, S_DEVR: begin
                                if (i_MstGetAck) begin
                                    if (retry_cnt < RETRY_MAX) begin
                                        retry_cnt <= retry_cnt + 4'd1;
                                        retrying  <= 1'b1;
                                    end else begin
                                        err_code <= 2'd1;
                                    end
                                    state <= S_STOP;
                                end else begin
                                    state <= (state == S_DEVW) ? S_REG : S_RDATA;
                                end
                            end
                            S_REG: begin
                                if (i_MstGetAck) begin
                                    err_code <= 2'd2;
                                    state    <= S_STOP;
                                end else begin
                                    state <= rd_req ? S_PRESTART : S_WDATA;
                                end
                            end
                            S_WDATA: begin
                                if (i_MstGetAck) err_code <= 2'd3;
                                state <= S_STOP;
                            end
                            S_RDATA: begin
                                o_RdValid <= 1'b1;
                                o_RdData  <= i_MstRxByte;
                                if (byte_cnt == rd_len) begin
                                    state <= S_STOP;
                                end else begin
                                    byte_cnt <= byte_cnt + 4'd1;
                                end
                            end
                            S_STOP: begin
                                if (retrying) begin
                                    retrying <= 1'b0;
                                    byte_cnt <= 4'd0;
                                    state    <= S_START;
                                end else begin
                                    o_RespValid <= 1'b1;
                                    o_RespErr   <= err_code;
                                    state       <= S_RESP;
                                end
                            end
                            default: state <= S_IDLE;
                        endcase
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_iic_reg_seq.sv
// tb/tb_iic_reg_seq.sv - scoreboard bench for iic_reg_seq with a behavioural I2C master
module tb_iic_reg_seq;
    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       req_valid = 1'b0;
    logic       o_ReqReady;
    logic       req_read = 1'b0;
    logic [6:0] dev_addr = 7'd0;
    logic [7:0] reg_addr = 8'd0;
    logic [7:0] wr_data = 8'd0;
    logic [3:0] rd_len = 4'd0;
    logic       o_RdValid;
    logic [7:0] o_RdData;
    logic       o_RespValid;
    logic [1:0] o_RespErr;
    logic       o_MstCmdValid;
    logic [3:0] o_MstCmd;
    logic [7:0] o_MstTxByte;
    logic       o_MstSetAck;
    logic       mst_done = 1'b1;
    logic       mst_ack = 1'b0;
    logic [7:0] mst_rx = 8'h00;

    iic_reg_seq #(.DEV_NACK_RETRY(2)) dut (
        .i_SysClock(clk), .i_ResetN(resetn),
        .i_ReqValid(req_valid), .o_ReqReady(o_ReqReady), .i_ReqRead(req_read),
        .i_DevAddr(dev_addr), .i_RegAddr(reg_addr), .i_WrData(wr_data), .i_RdLen(rd_len),
        .o_RdValid(o_RdValid), .o_RdData(o_RdData),
        .o_RespValid(o_RespValid), .o_RespErr(o_RespErr),
        .o_MstCmdValid(o_MstCmdValid), .o_MstCmd(o_MstCmd), .o_MstTxByte(o_MstTxByte),
        .o_MstSetAck(o_MstSetAck), .i_MstDone(mst_done), .i_MstGetAck(mst_ack),
        .i_MstRxByte(mst_rx)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] cmd;
        logic [7:0] tx;
        logic       sa;
        logic       ack;
        logic [7:0] rx;
    } cmd_t;

    cmd_t       exp_cmd[$];
    logic [7:0] exp_rd[$];
    logic [1:0] exp_resp[$];
    int checks = 0;
    int errors = 0;
    int resp_count = 0;
    int rd_count = 0;
    int busy = 0;
    logic       cur_ack = 1'b0;
    logic [7:0] cur_rx = 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pc(input logic [3:0] c, input logic [7:0] t, input logic sa,
                      input logic ak, input logic [7:0] rx);
        cmd_t e;
        e.cmd = c; e.tx = t; e.sa = sa; e.ack = ak; e.rx = rx;
        exp_cmd.push_back(e);
    endtask

    // Master model plus output monitors, all sampled on the falling edge
    always @(negedge clk) begin
        cmd_t e;
        if (!resetn) begin
            mst_done = 1'b1;
            busy = 0;
        end else begin
            if (busy > 0) begin
                busy--;
                if (busy == 0) begin
                    mst_ack  = cur_ack;
                    mst_rx   = cur_rx;
                    mst_done = 1'b1;
                end
            end
            if (o_MstCmdValid) begin
                if (exp_cmd.size() == 0) begin
                    chk("cmd_unexpected", 32'(o_MstCmd), 32'd0);
                end else begin
                    e = exp_cmd.pop_front();
                    chk("cmd", 32'(o_MstCmd), 32'(e.cmd));
                    if (e.cmd == 4'd2) chk("tx_byte", 32'(o_MstTxByte), 32'(e.tx));
                    if (e.cmd == 4'd3) chk("set_ack", 32'(o_MstSetAck), 32'(e.sa));
                    cur_ack  = e.ack;
                    cur_rx   = e.rx;
                    mst_done = 1'b0;
                    busy     = $urandom_range(1, 3);
                end
            end
            if (o_RdValid) begin
                rd_count++;
                if (exp_rd.size() == 0) chk("rd_unexpected", 32'(o_RdValid), 32'd0);
                else chk("rd_data", 32'(o_RdData), 32'(exp_rd.pop_front()));
            end
            if (o_RespValid) begin
                resp_count++;
                if (exp_resp.size() == 0) chk("resp_unexpected", 32'(o_RespValid), 32'd0);
                else chk("resp_err", 32'(o_RespErr), 32'(exp_resp.pop_front()));
            end
        end
    end

    task automatic issue_req(input logic rd, input logic [6:0] dev, input logic [7:0] ra,
                             input logic [7:0] wd, input logic [3:0] len);
        int n = 0;
        @(negedge clk);
        while (!o_ReqReady && n < 200) begin @(negedge clk); n++; end
        chk("req_ready_before", 32'(o_ReqReady), 32'd1);
        req_read = rd; dev_addr = dev; reg_addr = ra; wr_data = wd; rd_len = len;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_resp(input string tag);
        int target = resp_count + 1;
        int n = 0;
        logic early_ready = 1'b0;
        while (resp_count < target && n < 3000) begin
            @(negedge clk); #1; n++;
            if (resp_count < target && o_ReqReady) early_ready = 1'b1;
        end
        chk({tag, "_resp_seen"}, 32'(resp_count), 32'(target));
        chk({tag, "_ready_low_busy"}, 32'(early_ready), 32'd0);
        chk({tag, "_ready_low_resp"}, 32'(o_ReqReady), 32'd0);
        @(negedge clk); #1;
        chk({tag, "_ready_back"}, 32'(o_ReqReady), 32'd1);
        chk({tag, "_cmd_left"}, 32'(exp_cmd.size()), 32'd0);
        chk({tag, "_rd_left"}, 32'(exp_rd.size()), 32'd0);
        chk({tag, "_resp_left"}, 32'(exp_resp.size()), 32'd0);
    endtask

    task automatic push_write(input logic [6:0] dev, input logic [7:0] ra, input logic [7:0] wd);
        pc(4'd1, 8'h00, 1'b0, 1'b0, 8'h00);
        pc(4'd2, {dev, 1'b0}, 1'b0, 1'b0, 8'h00);
        pc(4'd2, ra, 1'b0, 1'b0, 8'h00);
        pc(4'd2, wd, 1'b0, 1'b0, 8'h00);
        pc(4'd4, 8'h00, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic push_read(input logic [6:0] dev, input logic [7:0] ra, input int nbytes,
                             input logic [7:0] base);
        pc(4'd1, 8'h00, 1'b0, 1'b0, 8'h00);
        pc(4'd2, {dev, 1'b0}, 1'b0, 1'b0, 8'h00);
        pc(4'd2, ra, 1'b0, 1'b0, 8'h00);
        pc(4'd5, 8'h00, 1'b0, 1'b0, 8'h00);
        pc(4'd1, 8'h00, 1'b0, 1'b0, 8'h00);
        pc(4'd2, {dev, 1'b1}, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < nbytes; i++) begin
            pc(4'd3, 8'h00, (i == nbytes - 1), 1'b0, base + 8'(i * 17));
            exp_rd.push_back(base + 8'(i * 17));
        end
        pc(4'd4, 8'h00, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic push_dev_nack(input logic [6:0] dev);
        pc(4'd1, 8'h00, 1'b0, 1'b0, 8'h00);
        pc(4'd2, {dev, 1'b0}, 1'b0, 1'b1, 8'h00);
        pc(4'd4, 8'h00, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_outputs",
            32'({o_ReqReady, o_MstCmdValid, o_MstCmd, o_MstTxByte, o_RdValid, o_RdData, o_RespValid, o_RespErr}),
            32'({1'b1, 1'b0, 4'd0, 8'd0, 1'b0, 8'd0, 1'b0, 2'd0}));
        resetn = 1'b1;

        push_write(7'h50, 8'h10, 8'hA5);
        exp_resp.push_back(2'd0);
        issue_req(1'b0, 7'h50, 8'h10, 8'hA5, 4'd0);
        wait_resp("write");

        // Slave bytes 0x11, 0x22, 0x33
        push_read(7'h50, 8'h02, 3, 8'h11);
        exp_resp.push_back(2'd0);
        issue_req(1'b1, 7'h50, 8'h02, 8'h00, 4'd2);
        wait_resp("read3");

        push_dev_nack(7'h50); push_dev_nack(7'h50); push_dev_nack(7'h50);
        exp_resp.push_back(2'd1);
        issue_req(1'b0, 7'h50, 8'h10, 8'h5A, 4'd0);
        wait_resp("dev_nack_all");

        push_dev_nack(7'h21);
        push_write(7'h21, 8'h33, 8'h44);
        exp_resp.push_back(2'd0);
        issue_req(1'b0, 7'h21, 8'h33, 8'h44, 4'd0);
        wait_resp("dev_nack_once");

        pc(4'd1, 8'h00, 1'b0, 1'b0, 8'h00);
        pc(4'd2, 8'hA0, 1'b0, 1'b0, 8'h00);
        pc(4'd2, 8'h7E, 1'b0, 1'b1, 8'h00);
        pc(4'd4, 8'h00, 1'b0, 1'b0, 8'h00);
        exp_resp.push_back(2'd2);
        issue_req(1'b0, 7'h50, 8'h7E, 8'h99, 4'd0);
        wait_resp("reg_nack");

        push_read(7'h3C, 8'h80, 16, 8'h40);
        exp_resp.push_back(2'd0);
        issue_req(1'b1, 7'h3C, 8'h80, 8'h00, 4'd15);
        repeat (20) @(negedge clk);
        req_valid = 1'b1; req_read = 1'b0; dev_addr = 7'h11; reg_addr = 8'h22; wr_data = 8'h33;
        repeat (8) @(negedge clk);
        #1 chk("busy_ready_low", 32'(o_ReqReady), 32'd0);
        req_valid = 1'b0;
        wait_resp("read16");
        chk("read16_rd_count", 32'(rd_count), 32'd19);

        push_read(7'h50, 8'h04, 4, 8'h90);
        exp_resp.push_back(2'd0);
        issue_req(1'b1, 7'h50, 8'h04, 8'h00, 4'd3);
        n = 0;
        while (rd_count < 20 && n < 500) begin @(negedge clk); #1; n++; end
        chk("pre_reset_first_byte", 32'(rd_count), 32'd20);
        @(negedge clk);
        resetn = 1'b0;
        #1;
        chk("midreset_outputs",
            32'({o_ReqReady, o_MstCmdValid, o_MstCmd, o_MstTxByte, o_RdValid, o_RdData, o_RespValid, o_RespErr}),
            32'({1'b1, 1'b0, 4'd0, 8'd0, 1'b0, 8'd0, 1'b0, 2'd0}));
        exp_cmd.delete(); exp_rd.delete(); exp_resp.delete();
        repeat (3) @(negedge clk);
        #1;
        chk("midreset_no_resp", 32'(resp_count), 32'd6);
        chk("midreset_no_more_rd", 32'(rd_count), 32'd20);
        resetn = 1'b1;

        push_write(7'h50, 8'h01, 8'hC3);
        exp_resp.push_back(2'd0);
        issue_req(1'b0, 7'h50, 8'h01, 8'hC3, 4'd0);
        wait_resp("post_reset_write");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
